// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, RV32
// field offsets, halt opcode and the buffered {inst, pc} entry.
package instr_fetch_pkg;

   localparam int unsigned INST_W     = 32;
   localparam int unsigned BUF_DEPTH  = 2;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned FUNCT3_LSB = 12;
   localparam int unsigned FUNCT3_W   = 3;
   localparam int unsigned FUNCT7_LSB = 25;
   localparam int unsigned FUNCT7_W   = 7;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE = 7'h7F;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [INST_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory port plus the decode interface.
// The master modport is the fetch stage, the slave modport is memory/decode.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic                  o_imem_req;
   logic [INST_W-1:0]     o_imem_addr;
   logic                  i_imem_ready;
   logic                  i_imem_rvalid;
   logic [INST_W-1:0]     i_imem_rdata;

   logic                  o_inst_valid;
   logic                  i_inst_ready;
   logic [INST_W-1:0]     o_inst;
   logic [INST_W-1:0]     o_inst_pc;
   logic [OPCODE_W-1:0]   o_opcode;
   logic [FUNCT3_W-1:0]   o_funct3;
   logic [FUNCT7_W-1:0]   o_funct7;

   logic                  i_redirect;
   logic [INST_W-1:0]     i_redirect_pc;
   logic                  i_halt;
   logic                  o_halted;
   logic                  o_misalign;

   modport master (
      output o_imem_req, o_imem_addr,
      input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
      output o_inst_valid, o_inst, o_inst_pc, o_opcode, o_funct3, o_funct7,
      input  i_inst_ready, i_redirect, i_redirect_pc, i_halt,
      output o_halted, o_misalign
   );

   modport slave (
      input  o_imem_req, o_imem_addr,
      output i_imem_ready, i_imem_rvalid, i_imem_rdata,
      input  o_inst_valid, o_inst, o_inst_pc, o_opcode, o_funct3, o_funct7,
      output i_inst_ready, i_redirect, i_redirect_pc, i_halt,
      input  o_halted, o_misalign
   );

endinterface

// File: rtl/instr_fetch_buf.sv
// Two-entry FIFO of fetched {inst, pc}; flush overrides push/pop in the
// same cycle, head is presented straight from the storage registers.
module instr_fetch_buf
   import instr_fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [BUF_DEPTH];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem read outstanding and
// feeds decode from a 2-entry buffer. Optional trap: IFETCH_MISALIGN_TRAP_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   instr_fetch_if.master bus
);

   fetch_state_e      state_q, state_d;
   logic [INST_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic              drop_q, drop_d;

   logic              accept, resp, consume, halt_now, redir, trap;
   logic              push, flush;
   logic [1:0]        cnt, cnt_next;
   fetch_entry_t      head, push_data;

   assign accept   = req_q && bus.i_imem_ready;
   assign resp     = (state_q == WAIT) && bus.i_imem_rvalid;
   assign consume  = (cnt != 2'd0) && bus.i_inst_ready;
   assign halt_now = consume && bus.i_halt;
   assign redir    = bus.i_redirect && !halt_now && (state_q != HALTED);

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign trap = redir && (bus.i_redirect_pc[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   assign flush     = redir || halt_now;
   assign push      = resp && !drop_q;
   assign push_data = '{inst: bus.i_imem_rdata, pc: addr_q};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      req_d    = req_q && !accept;
      drop_d   = drop_q;
      cnt_next = flush ? 2'd0 : cnt + {1'b0, push} - {1'b0, consume};

      case (state_q)
         FETCH:   if (accept) state_d = WAIT;
         WAIT:    if (bus.i_imem_rvalid) state_d = FETCH;
         default: ;
      endcase

      if (resp) drop_d = 1'b0;
      if (halt_now || trap) state_d = HALTED;

      // A request already presented or in flight still completes; only its data is discarded.
      if (redir && !trap) begin
         pc_d = word_align(bus.i_redirect_pc);
         if (req_q || ((state_q == WAIT) && !resp)) drop_d = 1'b1;
      end

      if ((state_d == FETCH) && !req_d && (cnt_next < 2'd2)) begin
         req_d  = 1'b1;
         addr_d = pc_d;
         pc_d   = pc_d + 32'd4;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_ADDR;
         addr_q  <= RESET_ADDR;
         req_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         drop_q  <= drop_d;
      end
   end

   instr_fetch_buf u_buf (
      .clk_i   (i_clk),
      .rst_ni  (i_rst),
      .push_i  (push),
      .pop_i   (consume),
      .flush_i (flush),
      .data_i  (push_data),
      .head_o  (head),
      .count_o (cnt)
   );

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic misalign_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) misalign_q <= 1'b0;
      else        misalign_q <= trap;
   end

   assign bus.o_misalign = misalign_q;
`else
   assign bus.o_misalign = 1'b0;
`endif

   assign bus.o_imem_req   = req_q;
   assign bus.o_imem_addr  = addr_q;
   assign bus.o_inst_valid = (cnt != 2'd0);
   assign bus.o_inst       = head.inst;
   assign bus.o_inst_pc    = head.pc;
   assign bus.o_opcode     = head.inst[OPCODE_LSB +: OPCODE_W];
   assign bus.o_funct3     = head.inst[FUNCT3_LSB +: FUNCT3_W];
   assign bus.o_funct7     = head.inst[FUNCT7_LSB +: FUNCT7_W];
   assign bus.o_halted     = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model answers requests, expected
// {inst, pc} pairs are queued by the stimulus and checked by a monitor on consume.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic clk;
   logic rst_n;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   int           checks = 0;
   int           errors = 0;
   int           cons_cnt = 0;
   fetch_entry_t exp_q[$];

   logic         mdl_rvalid, inj_rvalid, halt_en;
   logic [31:0]  mdl_rdata, inj_rdata;
   int           lat;
   logic         pend;
   int           pend_cnt;
   logic [31:0]  pend_addr;

   assign bus.i_imem_rvalid = mdl_rvalid | inj_rvalid;
   assign bus.i_imem_rdata  = inj_rvalid ? inj_rdata : mdl_rdata;
   assign bus.i_halt = halt_en && bus.o_inst_valid && (bus.o_opcode == HALT_OPCODE);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h0000_007F;
      if (a < 32'h0000_0008)  return 32'h0000_0013;
      return (a << 12) | 32'h0000_0013;
   endfunction

   task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc);
      fetch_entry_t e;
      e.inst = inst;
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   task automatic wait_cons(input int target, input string name);
      int n = 0;
      while (cons_cnt < target && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(cons_cnt >= target), 32'd1);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = target;
      @(posedge clk); #1;
      bus.i_redirect    = 1'b0;
   endtask

   // Memory: rvalid arrives lat cycles after acceptance; a reset loses the pending read.
   initial begin : mem_model
      mdl_rvalid = 1'b0;
      mdl_rdata  = '0;
      pend       = 1'b0;
      pend_cnt   = 0;
      pend_addr  = '0;
      forever begin
         @(negedge clk);
         mdl_rvalid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (pend_cnt == 0) begin
                  mdl_rvalid = 1'b1;
                  mdl_rdata  = mem_word(pend_addr);
                  pend       = 1'b0;
               end else begin
                  pend_cnt--;
               end
            end
            if (bus.o_imem_req && bus.i_imem_ready) begin
               pend      = 1'b1;
               pend_cnt  = lat - 1;
               pend_addr = bus.o_imem_addr;
            end
         end
      end
   end

   initial begin : monitor
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_inst_valid && bus.i_inst_ready) begin
            cons_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_inst_pc", bus.o_inst_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("inst",    bus.o_inst,           e.inst);
               check("inst_pc", bus.o_inst_pc,        e.pc);
               check("opcode",  32'(bus.o_opcode),    32'(e.inst[6:0]));
               check("funct3",  32'(bus.o_funct3),    32'(e.inst[14:12]));
               check("funct7",  32'(bus.o_funct7),    32'(e.inst[31:25]));
            end
         end
      end
   end

   initial begin : stimulus
      logic found;
      rst_n              = 1'b0;
      bus.i_imem_ready   = 1'b1;
      bus.i_inst_ready   = 1'b0;
      bus.i_redirect     = 1'b0;
      bus.i_redirect_pc  = '0;
      halt_en            = 1'b0;
      inj_rvalid         = 1'b0;
      inj_rdata          = '0;
      lat                = 1;

      repeat (2) @(negedge clk);
      check("rst_req",      32'(bus.o_imem_req),   32'd0);
      check("rst_addr",     bus.o_imem_addr,       32'h0);
      check("rst_valid",    32'(bus.o_inst_valid), 32'd0);
      check("rst_inst",     bus.o_inst,            32'h0);
      check("rst_inst_pc",  bus.o_inst_pc,         32'h0);
      check("rst_halted",   32'(bus.o_halted),     32'd0);
      check("rst_misalign", 32'(bus.o_misalign),   32'd0);

      @(posedge clk); #1;
      rst_n = 1'b1;

      // Decode stalled: two words buffered, fetch stops, head held.
      repeat (12) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_req",     32'(bus.o_imem_req),   32'd0);
         check("full_valid",   32'(bus.o_inst_valid), 32'd1);
         check("full_inst_pc", bus.o_inst_pc,         32'h0);
         check("full_inst",    bus.o_inst,            32'h0000_0013);
      end

      @(posedge clk); #1;
      lat = 4;
      push_exp(32'h0000_0013, 32'h0);
      push_exp(32'h0000_0013, 32'h4);
      bus.i_inst_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (bus.o_imem_req && bus.o_imem_addr == 32'h8) found = 1'b1;
      end
      check("req_0x8", 32'(found), 32'd1);

      // 0x8 accepted at this edge and now in flight; redirect away from it.
      @(posedge clk); #1;
      push_exp(32'h0010_0013, 32'h100);
      pulse_redirect(32'h0000_0100);
      lat = 1;
      wait_cons(3, "cons_redirect_0x100");
      bus.i_inst_ready = 1'b0;

      repeat (6) @(posedge clk);
      #1;
      halt_en = 1'b1;
      push_exp(32'h0000_007F, 32'h200);
      pulse_redirect(32'h0000_0200);
      bus.i_inst_ready = 1'b1;
      wait_cons(4, "cons_halt");
      bus.i_inst_ready = 1'b0;
      check("halted",       32'(bus.o_halted),     32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halted_req", 32'(bus.o_imem_req), 32'd0);
      end
      check("halted_valid", 32'(bus.o_inst_valid), 32'd0);
      check("halted_hold",  32'(bus.o_halted),     32'd1);

      // Reset leaves HALTED, then reset again while a read is in flight.
      @(posedge clk); #1;
      halt_en = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("async_rst_halted", 32'(bus.o_halted), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      lat   = 5;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midwait_rst_req",   32'(bus.o_imem_req),   32'd0);
      check("midwait_rst_valid", 32'(bus.o_inst_valid), 32'd0);
      bus.i_imem_ready = 1'b0;
      lat = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      inj_rdata  = 32'hDEAD_BEEF;
      inj_rvalid = 1'b1;
      @(posedge clk); #1;
      inj_rvalid = 1'b0;
      bus.i_imem_ready = 1'b1;
      push_exp(32'h0000_0013, 32'h0);
      bus.i_inst_ready = 1'b1;
      wait_cons(5, "cons_after_reset");
      bus.i_inst_ready = 1'b0;

      // Misaligned redirect target.
      repeat (6) @(posedge clk);
      #1;
`ifdef IFETCH_MISALIGN_TRAP_EN
      pulse_redirect(32'h0000_0102);
      check("misalign_pulse",  32'(bus.o_misalign),   32'd1);
      check("misalign_halted", 32'(bus.o_halted),     32'd1);
      @(posedge clk); #1;
      check("misalign_clear",  32'(bus.o_misalign),   32'd0);
      check("misalign_valid",  32'(bus.o_inst_valid), 32'd0);
      repeat (4) @(negedge clk);
      check("misalign_no_req", 32'(bus.o_imem_req),   32'd0);
`else
      push_exp(32'h0010_0013, 32'h100);
      pulse_redirect(32'h0000_0102);
      check("misalign_tied", 32'(bus.o_misalign), 32'd0);
      check("misalign_run",  32'(bus.o_halted),   32'd0);
      bus.i_inst_ready = 1'b1;
      wait_cons(6, "cons_misalign_0x100");
      bus.i_inst_ready = 1'b0;
`endif

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the PC, issues word reads to instruction memory, buffers returned words and presents them, with PC and pre-split opcode/funct3/funct7 fields, to the decode stage (control unit). It is the producer side of the decoder interface, consuming the decoder's jump redirect and halt indications to steer or stop fetching.

## Interface
- RESET_ADDR, 32'h0000_0000, PC fetched first after reset
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- o_imem_req  out  1  read request; held with o_imem_addr until accepted
- o_imem_addr  out  32  word address (bits [1:0] always 0)
- i_imem_ready  in  1  request accepted when o_imem_req && i_imem_ready
- i_imem_rvalid  in  1  read data valid; in order, ≥1 cycle after acceptance
- i_imem_rdata  in  32  instruction word
- o_inst_valid  out  1  instruction available to decode
- i_inst_ready  in  1  decode consumes when o_inst_valid && i_inst_ready
- o_inst  out  32  instruction word
- o_inst_pc  out  32  PC of o_inst
- o_opcode / o_funct3 / o_funct7  out  7/3/7  o_inst[6:0], [14:12], [31:25]
- i_redirect  in  1  jump/branch taken, one-cycle pulse
- i_redirect_pc  in  32  target PC
- i_halt  in  1  decoder halt for the instruction on o_inst
- o_halted  out  1  fetch stopped
- o_misalign  out  1  misaligned redirect (IFETCH_MISALIGN_TRAP_EN only)

## Operation
- States: FETCH (may request), WAIT (one request outstanding), HALTED.
- At most one outstanding request. Request issued only when buffer count + outstanding < 2.
- On accept: fetch PC += 4, go WAIT. On i_imem_rvalid in WAIT: push {rdata, pc} into 2-entry buffer unless drop flag set; return to FETCH.
- i_imem_rvalid with nothing outstanding is ignored.
- Redirect: flush buffer, fetch PC <= i_redirect_pc with [1:0] forced 0. Outstanding or unaccepted-but-presented request completes normally; its response is dropped (drop flag). Redirect same cycle as rvalid: data dropped. Redirect same cycle as consume: consume occurs, then flush.
- Halt: consume with i_halt=1 → HALTED. Buffer flushed, no new requests; pending request still held until accepted, response dropped. Only reset leaves HALTED. Halt and redirect same cycle: halt wins.
- Reset values: o_imem_req 0, o_imem_addr RESET_ADDR, o_inst_valid 0, o_inst/o_inst_pc/fields 0, o_halted 0, o_misalign 0, state FETCH, buffer empty, drop flag 0.

## Timing
- First request in the first cycle after i_rst deasserts, address RESET_ADDR.
- rvalid at edge t → o_inst_valid at t+1 (registered buffer output); with i_imem_ready and rvalid both 1-cycle, steady throughput one instruction per 2 cycles.
- Redirect at edge t → o_inst_valid 0 from t+1; request for target issued at t+1 if none pending, else after pending request is accepted.
- Buffer full → o_imem_req 0; outputs stable while o_inst_valid && !i_inst_ready.
- Async reset asserted mid-operation clears all state immediately; o_halted drops.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined: redirect with i_redirect_pc[1:0] ≠ 0 pulses o_misalign for one cycle and enters HALTED (o_halted=1), no fetch of target.
- Undefined: o_misalign tied 0; low bits silently cleared.

## Structure
- Shared package: fetch state enum, RV32 field offsets (opcode/funct3/funct7), halt opcode constant, instruction width 32.
- Sub-module fetch_buf: 2-entry FIFO of {inst, pc} with push, pop, flush, count.

## Test plan
- Reset, memory returns 32'h00000013 at 0x0 and 0x4, ready always 1 → o_inst_pc 0x0 then 0x4, o_opcode 7'h13.
- Hold i_inst_ready=0 → exactly 2 words buffered, o_imem_req 0, outputs stable; release → 0x8 requested.
- Redirect to 0x100 while request to 0x8 outstanding → 0x8 data dropped, next o_inst_pc 0x100.
- Consume word 32'h0000007F with i_halt=1 → o_halted=1 next cycle, o_imem_req stays 0 for 20 cycles.
- Redirect to 0x102: with IFETCH_MISALIGN_TRAP_EN → o_misalign pulse, halted; without → next o_inst_pc 0x100.
- Assert i_rst mid-WAIT, late rvalid after release ignored → first o_inst_pc = RESET_ADDR.
